// File: rtl/demux1_16_8b_reg.sv
// Registered 1-to-16 byte distributor with per-lane valid tracking,
// an auto-increment write pointer and a sticky overwrite flag.
module demux1_16_8b_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             sel3,
    input  logic             sel2,
    input  logic             sel1,
    input  logic             sel0,
    input  logic             we,
    input  logic             auto,
    input  logic             clr,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [WIDTH-1:0] out8,
    output logic [WIDTH-1:0] out9,
    output logic [WIDTH-1:0] out10,
    output logic [WIDTH-1:0] out11,
    output logic [WIDTH-1:0] out12,
    output logic [WIDTH-1:0] out13,
    output logic [WIDTH-1:0] out14,
    output logic [WIDTH-1:0] out15,
    output logic [15:0]      valid,
    output logic [3:0]       ptr,
    output logic             full,
    output logic             ovr
);

    // One-hot lane enable for a 4-bit lane index.
    function automatic logic [15:0] lane_decode(input logic [3:0] idx);
        logic [15:0] onehot;
        onehot = 16'h0000;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

    logic [WIDTH-1:0] lane_r [16];
    logic [15:0]      valid_r;
    logic [3:0]       ptr_r;
    logic             ovr_r;
    logic [3:0]       tgt_s;
    logic [15:0]      hit_s;
    logic             tgt_valid_s;

    // Resolve the target lane from the pointer or the manual select bits.
    always_comb begin
        tgt_s = 4'd0;
        if (auto) begin
            tgt_s = ptr_r;
        end else begin
            tgt_s = {sel3, sel2, sel1, sel0};
        end
    end

    // Decode the write strobe onto the target lane.
    always_comb begin
        hit_s       = 16'h0000;
        tgt_valid_s = valid_r[tgt_s];
        if (we) begin
            hit_s = lane_decode(tgt_s);
        end else begin
            hit_s = 16'h0000;
        end
    end

    // Lane storage: clr wipes every lane, a write updates only the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                lane_r[k] <= '0;
            end
        end else if (clr) begin
            for (int k = 0; k < 16; k++) begin
                lane_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (hit_s[k]) begin
                    lane_r[k] <= in;
                end
            end
        end
    end

    // Bookkeeping: valid flags, write pointer and sticky overwrite flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 16'h0000;
            ptr_r   <= 4'd0;
            ovr_r   <= 1'b0;
        end else if (clr) begin
            valid_r <= 16'h0000;
            ptr_r   <= 4'd0;
            ovr_r   <= 1'b0;
        end else if (we) begin
            valid_r <= valid_r | hit_s;
            if (tgt_valid_s) begin
                ovr_r <= 1'b1;
            end
            // Pointer only advances on auto-mode writes; 4-bit add wraps 15 -> 0.
            if (auto) begin
                ptr_r <= ptr_r + 4'd1;
            end
        end
    end

    assign out0  = lane_r[0];
    assign out1  = lane_r[1];
    assign out2  = lane_r[2];
    assign out3  = lane_r[3];
    assign out4  = lane_r[4];
    assign out5  = lane_r[5];
    assign out6  = lane_r[6];
    assign out7  = lane_r[7];
    assign out8  = lane_r[8];
    assign out9  = lane_r[9];
    assign out10 = lane_r[10];
    assign out11 = lane_r[11];
    assign out12 = lane_r[12];
    assign out13 = lane_r[13];
    assign out14 = lane_r[14];
    assign out15 = lane_r[15];
    assign valid = valid_r;
    assign ptr   = ptr_r;
    assign ovr   = ovr_r;
    // full is derived from the registered valid flags, so it never depends on in.
    assign full  = &valid_r;

endmodule

// File: tb/tb_demux1_16_8b_reg.sv
// Directed bench for demux1_16_8b_reg: a vector table for single-cycle
// operations plus hand sequences for fill, wrap, clear and async reset.
module tb_demux1_16_8b_reg;

    logic        clk;
    logic        rst;
    logic [7:0]  in;
    logic        sel3, sel2, sel1, sel0;
    logic        we, auto, clr;
    logic [7:0]  out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]  out8, out9, out10, out11, out12, out13, out14, out15;
    logic [15:0] valid;
    logic [3:0]  ptr;
    logic        full, ovr;
    logic [7:0]  outs [16];

    int checks = 0;
    int errors = 0;

    demux1_16_8b_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in(in),
        .sel3(sel3), .sel2(sel2), .sel1(sel1), .sel0(sel0),
        .we(we), .auto(auto), .clr(clr),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out8(out8), .out9(out9), .out10(out10), .out11(out11),
        .out12(out12), .out13(out13), .out14(out14), .out15(out15),
        .valid(valid), .ptr(ptr), .full(full), .ovr(ovr)
    );

    assign outs[0]  = out0;  assign outs[1]  = out1;
    assign outs[2]  = out2;  assign outs[3]  = out3;
    assign outs[4]  = out4;  assign outs[5]  = out5;
    assign outs[6]  = out6;  assign outs[7]  = out7;
    assign outs[8]  = out8;  assign outs[9]  = out9;
    assign outs[10] = out10; assign outs[11] = out11;
    assign outs[12] = out12; assign outs[13] = out13;
    assign outs[14] = out14; assign outs[15] = out15;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        we;
        logic        auto;
        logic [3:0]  sel;
        logic [7:0]  din;
        logic [3:0]  lane;
        logic [7:0]  exp_lane;
        logic [15:0] exp_valid;
        logic [3:0]  exp_ptr;
        logic        exp_ovr;
        logic        exp_full;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [15:0] ev, input logic [3:0] ep,
                             input logic eo, input logic ef);
        chk({name, ".valid"}, valid, ev);
        chk({name, ".ptr"}, {12'h000, ptr}, {12'h000, ep});
        chk({name, ".ovr"}, {15'h0000, ovr}, {15'h0000, eo});
        chk({name, ".full"}, {15'h0000, full}, {15'h0000, ef});
    endtask

    task automatic chk_all_lanes(input string name, input logic [7:0] ev);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("%s.out%0d", name, k), {8'h00, outs[k]}, {8'h00, ev});
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic c, input logic w, input logic a,
                        input logic [3:0] s, input logic [7:0] d);
        clr = c; we = w; auto = a; in = d;
        {sel3, sel2, sel1, sel0} = s;
        @(posedge clk);
        #1;
        clr = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in = 8'h00; we = 1'b0; auto = 1'b0; clr = 1'b0;
        {sel3, sel2, sel1, sel0} = 4'h0;

        //                clr   we    auto  sel    din    lane  exp    valid     ptr   ovr   full
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'hA, 8'hA5, 4'hA, 8'hA5, 16'h0400, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 4'hA, 8'h00, 16'h0000, 4'h0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'h3, 8'h11, 4'h3, 8'h11, 16'h0008, 4'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'h3, 8'h22, 4'h3, 8'h22, 16'h0008, 4'h0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h3, 8'h77, 4'h3, 8'h22, 16'h0008, 4'h0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 4'h3, 8'h00, 16'h0000, 4'h0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'hF, 8'hA0, 4'h0, 8'hA0, 16'h0001, 4'h1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'hF, 8'hA1, 4'h1, 8'hA1, 16'h0003, 4'h2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 4'h9, 8'h99, 4'h9, 8'h99, 16'h0203, 4'h2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'h9, 8'hA2, 4'h2, 8'hA2, 16'h0207, 4'h3, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 4'h0, 8'hBB, 4'h3, 8'h00, 16'h0207, 4'h3, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'h9, 8'h9A, 4'h9, 8'h9A, 16'h0207, 4'h3, 1'b1, 1'b0};

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_lanes("reset", 8'h00);
        chk_state("reset", 16'h0000, 4'h0, 1'b0, 1'b0);

        // Vector table; vec 0 also checks that no other lane was touched.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].clr, vecs[i].we, vecs[i].auto, vecs[i].sel, vecs[i].din);
            chk($sformatf("vec%0d.lane", i), {8'h00, outs[vecs[i].lane]}, {8'h00, vecs[i].exp_lane});
            chk_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ptr,
                      vecs[i].exp_ovr, vecs[i].exp_full);
            if (i == 0) begin
                for (int k = 0; k < 16; k++) begin
                    if (k != 10) chk($sformatf("vec0.other%0d", k), {8'h00, outs[k]}, 16'h0000);
                end
            end
        end

        // Auto fill of all 16 lanes, full only after the 16th write.
        step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1, 1'b1, 4'h0, 8'h10 + k[7:0]);
            if (k == 14) chk("fill15.full", {15'h0000, full}, 16'h0000);
        end
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("fill.out%0d", k), {8'h00, outs[k]}, {8'h00, 8'h10 + k[7:0]});
        end
        chk_state("fill", 16'hFFFF, 4'h0, 1'b0, 1'b1);

        // 17th write while full wraps onto lane 0 and flags overwrite.
        step(1'b0, 1'b1, 1'b1, 4'h7, 8'hEE);
        chk("wrap.out0", {8'h00, out0}, 16'h00EE);
        chk("wrap.out1", {8'h00, out1}, 16'h0011);
        chk_state("wrap", 16'hFFFF, 4'h1, 1'b1, 1'b1);

        // clr wins over a simultaneous auto write from a half-filled bank.
        step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1, 4'h0, 8'hC0 + k[7:0]);
        chk_state("half", 16'h00FF, 4'h8, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'h0, 8'h55);
        chk_all_lanes("clrwe", 8'h00);
        chk_state("clrwe", 16'h0000, 4'h0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle clears state before the next edge.
        step(1'b0, 1'b1, 1'b1, 4'h0, 8'h3C);
        step(1'b0, 1'b1, 1'b0, 4'h5, 8'h5A);
        step(1'b0, 1'b1, 1'b0, 4'h5, 8'h5B);
        chk("pre_rst.out5", {8'h00, out5}, 16'h005B);
        chk_state("pre_rst", 16'h0021, 4'h1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_all_lanes("async_rst", 8'h00);
        chk_state("async_rst", 16'h0000, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // First write after release behaves as after power-up.
        step(1'b0, 1'b1, 1'b1, 4'h0, 8'h42);
        chk("post_rst.out0", {8'h00, out0}, 16'h0042);
        chk_state("post_rst", 16'h0001, 4'h1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
